// File: rtl/biriscv_ram_arbiter.sv
// Shares one single-ported RAM between instruction fetch (read-only) and data (read/write).
// Data has fixed priority; a starvation counter guarantees fetch forward progress.
module biriscv_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 20,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      ifetch_req_i,
    input  logic [ADDR_WIDTH-1:0]     ifetch_addr_i,
    input  logic                      ifetch_flush_i,
    output logic                      ifetch_accept_o,
    output logic                      ifetch_valid_o,
    output logic [DATA_WIDTH-1:0]     ifetch_rdata_o,

    input  logic                      dmem_req_i,
    input  logic                      dmem_we_i,
    input  logic [ADDR_WIDTH-1:0]     dmem_addr_i,
    input  logic [DATA_WIDTH-1:0]     dmem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   dmem_wstrb_i,
    output logic                      dmem_accept_o,
    output logic                      dmem_ack_o,
    output logic [DATA_WIDTH-1:0]     dmem_rdata_o,

    output logic                      ram_req_o,
    output logic                      ram_we_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   ram_wstrb_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_cnt_nxt;
    logic             resp_if;
    logic             resp_d;
    logic             starved;
    logic             grant_if;
    logic             grant_d;

    // Grant decision and starvation counter update
    always_comb begin
        starved        = (starve_cnt == CNT_MAX);
        grant_if       = 1'b0;
        grant_d        = 1'b0;
        starve_cnt_nxt = starve_cnt;

        if (!rst_i) begin
            grant_if = ifetch_req_i & (~dmem_req_i | starved);
            grant_d  = dmem_req_i & ~grant_if;
        end

        if (grant_if || !ifetch_req_i) begin
            starve_cnt_nxt = '0;
        end else if (grant_d && !starved) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

    // RAM request mux; a fetch grant never writes
    always_comb begin
        ram_req_o   = grant_if | grant_d;
        ram_we_o    = dmem_we_i;
        ram_addr_o  = dmem_addr_i;
        ram_wdata_o = dmem_wdata_i;
        ram_wstrb_o = dmem_wstrb_i;
        if (grant_if) begin
            ram_we_o    = 1'b0;
            ram_addr_o  = ifetch_addr_i;
            ram_wstrb_o = STRB_W'(0);
        end
    end

    // Response ownership for the one-cycle read latency; reset drops anything in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_if    <= 1'b0;
            resp_d     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            resp_if    <= grant_if;
            resp_d     <= grant_d;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    assign ifetch_accept_o = grant_if;
    assign dmem_accept_o   = grant_d;
    assign ifetch_valid_o  = resp_if & ~ifetch_flush_i;
    assign dmem_ack_o      = resp_d;
    assign ifetch_rdata_o  = ram_rdata_i;
    assign dmem_rdata_o    = ram_rdata_i;

endmodule

// File: tb/tb_biriscv_ram_arbiter.sv
// Directed bench for biriscv_ram_arbiter with a small behavioural RAM behind it.
module tb_biriscv_ram_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifetch_req = 1'b0;
    logic [AW-1:0] ifetch_addr = '0;
    logic          ifetch_flush = 1'b0;
    logic          ifetch_accept;
    logic          ifetch_valid;
    logic [DW-1:0] ifetch_rdata;
    logic          dmem_req = 1'b0;
    logic          dmem_we = 1'b0;
    logic [AW-1:0] dmem_addr = '0;
    logic [DW-1:0] dmem_wdata = '0;
    logic [SW-1:0] dmem_wstrb = '0;
    logic          dmem_accept;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [SW-1:0] ram_wstrb;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    biriscv_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .ifetch_req_i(ifetch_req), .ifetch_addr_i(ifetch_addr), .ifetch_flush_i(ifetch_flush),
        .ifetch_accept_o(ifetch_accept), .ifetch_valid_o(ifetch_valid), .ifetch_rdata_o(ifetch_rdata),
        .dmem_req_i(dmem_req), .dmem_we_i(dmem_we), .dmem_addr_i(dmem_addr),
        .dmem_wdata_i(dmem_wdata), .dmem_wstrb_i(dmem_wstrb),
        .dmem_accept_o(dmem_accept), .dmem_ack_o(dmem_ack), .dmem_rdata_o(dmem_rdata),
        .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_wstrb_o(ram_wstrb), .ram_rdata_i(ram_rdata)
    );

    // Single-ported RAM: registered read returns the pre-write word
    always @(posedge clk) begin
        if (ram_req) begin
            ram_rdata <= mem[ram_addr[7:0]];
            if (ram_we) begin
                for (int b = 0; b < int'(SW); b++) begin
                    if (ram_wstrb[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive after the edge, check at the falling edge
    task automatic cyc(input string tag, input logic ireq, input logic [AW-1:0] iaddr, input logic flush,
                       input logic dreq, input logic dwe, input logic [AW-1:0] daddr,
                       input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                       input logic e_iacc, input logic e_dacc, input logic e_ival, input logic e_dack);
        @(posedge clk);
        #1;
        ifetch_req = ireq; ifetch_addr = iaddr; ifetch_flush = flush;
        dmem_req = dreq; dmem_we = dwe; dmem_addr = daddr; dmem_wdata = wdata; dmem_wstrb = strb;
        @(negedge clk);
        check({tag, ".iacc"}, 64'(ifetch_accept), 64'(e_iacc));
        check({tag, ".dacc"}, 64'(dmem_accept), 64'(e_dacc));
        check({tag, ".ramreq"}, 64'(ram_req), 64'(e_iacc | e_dacc));
        check({tag, ".ival"}, 64'(ifetch_valid), 64'(e_ival));
        check({tag, ".dack"}, 64'(dmem_ack), 64'(e_dack));
        if (e_iacc) begin
            check({tag, ".iaddr"}, 64'(ram_addr), 64'(iaddr));
            check({tag, ".iwe"}, 64'(ram_we), 64'(0));
            check({tag, ".istrb"}, 64'(ram_wstrb), 64'(0));
        end
        if (e_dacc) begin
            check({tag, ".daddr"}, 64'(ram_addr), 64'(daddr));
            check({tag, ".dwe"}, 64'(ram_we), 64'(dwe));
        end
    endtask

    task automatic idle(input string tag, input logic e_ival, input logic e_dack);
        cyc(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, e_ival, e_dack);
    endtask

    task automatic ifr(input string tag, input logic [AW-1:0] a, input logic e_ival, input logic e_dack);
        cyc(tag, 1'b1, a, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, e_ival, e_dack);
    endtask

    task automatic drd(input string tag, input logic [AW-1:0] a, input logic e_ival, input logic e_dack);
        cyc(tag, 1'b0, '0, 1'b0, 1'b1, 1'b0, a, '0, '0, 1'b0, 1'b1, e_ival, e_dack);
    endtask

    task automatic dwr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic e_ival, input logic e_dack);
        cyc(tag, 1'b0, '0, 1'b0, 1'b1, 1'b1, a, d, s, 1'b0, 1'b1, e_ival, e_dack);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_rdata = '0;

        // Grants forced off while reset is held, even with both ports requesting
        ifetch_req = 1'b1;
        dmem_req   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst.iacc", 64'(ifetch_accept), 64'(0));
        check("rst.dacc", 64'(dmem_accept), 64'(0));
        check("rst.ramreq", 64'(ram_req), 64'(0));
        check("rst.ival", 64'(ifetch_valid), 64'(0));
        check("rst.dack", 64'(dmem_ack), 64'(0));
        check("rst.cnt", 64'(dut.starve_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0; ifetch_req = 1'b0; dmem_req = 1'b0;

        // Single reads
        dwr("c1", 20'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        ifr("c2", 20'h10, 1'b0, 1'b1);
        idle("c3", 1'b1, 1'b0);
        check("c3.irdata", 64'(ifetch_rdata), 64'hDEADBEEF);

        // Byte strobes
        dwr("c4", 20'h20, 32'h11223344, 4'h5, 1'b0, 1'b0);
        drd("c5", 20'h20, 1'b0, 1'b1);
        idle("c6", 1'b0, 1'b1);
        check("c6.drdata", 64'(dmem_rdata), 64'h00220044);

        // Starvation: both requesting, fetch wins every fifth cycle
        for (int k = 0; k < 10; k++) begin
            logic g_if, p_if, p_d;
            g_if = ((k % 5) == 4);
            p_if = (k > 0) && (((k - 1) % 5) == 4);
            p_d  = (k > 0) && !p_if;
            cyc("starve", 1'b1, 20'h10, 1'b0, 1'b1, 1'b0, 20'h20, '0, '0, g_if, !g_if, p_if, p_d);
            check("starve.cnt", 64'(dut.starve_cnt), 64'(k % 5));
            if (p_if) check("starve.irdata", 64'(ifetch_rdata), 64'hDEADBEEF);
            if (p_d)  check("starve.drdata", 64'(dmem_rdata), 64'h00220044);
        end
        idle("s_end", 1'b1, 1'b0);
        check("s_end.cnt", 64'(dut.starve_cnt), 64'(0));

        // Flush suppresses the due response; a fetch in the flush cycle still returns
        ifr("f1", 20'h10, 1'b0, 1'b0);
        cyc("f2", 1'b1, 20'h20, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("f3", 1'b1, 1'b0);
        check("f3.irdata", 64'(ifetch_rdata), 64'h00220044);
        idle("f4", 1'b0, 1'b0);
        drd("f5", 20'h20, 1'b0, 1'b0);
        cyc("f6", 1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-flight drops the outstanding ack and clears the counter
        cyc("r0a", 1'b1, 20'h10, 1'b0, 1'b1, 1'b0, 20'h20, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("r0b", 1'b1, 20'h10, 1'b0, 1'b1, 1'b0, 20'h20, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("r1", 1'b1, 20'h10, 1'b0, 1'b1, 1'b0, 20'h20, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("r1.cnt", 64'(dut.starve_cnt), 64'(2));
        #1;
        rst = 1'b1;
        #1;
        check("rpulse.dack", 64'(dmem_ack), 64'(0));
        check("rpulse.dacc", 64'(dmem_accept), 64'(0));
        check("rpulse.ramreq", 64'(ram_req), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0; ifetch_req = 1'b0; dmem_req = 1'b0;
        #1;
        check("rrel.dack", 64'(dmem_ack), 64'(0));
        check("rrel.cnt", 64'(dut.starve_cnt), 64'(0));
        idle("r2", 1'b0, 1'b0);
        cyc("p1", 1'b1, 20'h10, 1'b0, 1'b1, 1'b0, 20'h20, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("p2", 1'b0, 1'b1);

        // Back-to-back mix fetch/dmem/fetch
        dwr("w0", 20'h0, 32'hA0A0A0A0, 4'hF, 1'b0, 1'b0);
        dwr("w1", 20'h1, 32'hA1A1A1A1, 4'hF, 1'b0, 1'b1);
        dwr("w2", 20'h2, 32'hA2A2A2A2, 4'hF, 1'b0, 1'b1);
        ifr("b1", 20'h0, 1'b0, 1'b1);
        drd("b2", 20'h1, 1'b1, 1'b0);
        check("b2.irdata", 64'(ifetch_rdata), 64'hA0A0A0A0);
        ifr("b3", 20'h2, 1'b0, 1'b1);
        check("b3.drdata", 64'(dmem_rdata), 64'hA1A1A1A1);
        idle("b4", 1'b1, 1'b0);
        check("b4.irdata", 64'(ifetch_rdata), 64'hA2A2A2A2);
        idle("b5", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
